// File: rtl/change_pkg.sv
// Shared types and coin constants for the change dispenser.
// Coin codes double as their nickel values.
package change_pkg;

    typedef enum logic [2:0] {
        NONE    = 3'b000,
        NICKEL  = 3'b001,
        DIME    = 3'b010,
        QUARTER = 3'b101
    } coin_e;

    localparam int Q_VAL = 5;
    localparam int D_VAL = 2;
    localparam int N_VAL = 1;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        DISPENSE,
        DONE
    } state_e;

    function automatic logic [2:0] coin_val(input coin_e c);
        logic [2:0] v;
        v = 3'd0;
        case (c)
            QUARTER: v = 3'(Q_VAL);
            DIME:    v = 3'(D_VAL);
            NICKEL:  v = 3'(N_VAL);
            default: v = 3'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/change_dispenser_seq_if.sv
// Transaction, coin-eject and status bundle between
// the payment front-end, the dispenser and the ejector.
interface change_dispenser_seq_if #(
    parameter int AMT_W = 6
);
    logic             txn_valid;
    logic             txn_ready;
    logic [AMT_W-1:0] cost;
    logic [AMT_W-1:0] paid;
    logic             coin_valid;
    logic             coin_ready;
    logic [2:0]       coin_value;
    logic             done;
    logic             exact_amount;
    logic             cough_up_more;
    logic             not_enough_change;
    logic [AMT_W-1:0] remaining;

    modport master (
        output txn_valid, cost, paid, coin_ready,
        input  txn_ready, coin_valid, coin_value,
        input  done, exact_amount, cough_up_more,
        input  not_enough_change, remaining
    );

    modport slave (
        input  txn_valid, cost, paid, coin_ready,
        output txn_ready, coin_valid, coin_value,
        output done, exact_amount, cough_up_more,
        output not_enough_change, remaining
    );
endinterface

// File: rtl/change_dispenser_seq_coin_select.sv
// Greedy coin pick: largest coin that fits owed and is
// still in stock; NONE when nothing qualifies.
module coin_select
    import change_pkg::*;
#(
    parameter int AMT_W = 6,
    parameter int CNT_W = 4
) (
    input  logic [AMT_W-1:0] owed,
    input  logic [CNT_W-1:0] q,
    input  logic [CNT_W-1:0] d,
    input  logic [CNT_W-1:0] n,
    output coin_e            coin
);

    // Priority chain quarter > dime > nickel
    always_comb begin
        coin = NONE;
        if (owed >= AMT_W'(Q_VAL) && q != '0)
            coin = QUARTER;
        else if (owed >= AMT_W'(D_VAL) && d != '0)
            coin = DIME;
        else if (owed >= AMT_W'(N_VAL) && n != '0)
            coin = NICKEL;
    end

endmodule

// File: rtl/change_dispenser_seq.sv
// Change dispenser with its own coin inventory; pays
// change one coin per handshake, largest first.
module change_dispenser_seq
    import change_pkg::*;
#(
    parameter int AMT_W = 6,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restock_valid,
    input  logic [CNT_W-1:0] restock_q,
    input  logic [CNT_W-1:0] restock_d,
    input  logic [CNT_W-1:0] restock_n,
    change_dispenser_seq_if.slave bus,
    output logic [CNT_W-1:0] inv_q,
    output logic [CNT_W-1:0] inv_d,
    output logic [CNT_W-1:0] inv_n
);

    state_e         state_q, state_d;
    logic [AMT_W:0] owed_q, owed_nx, take;
    coin_e          coin_q, sel;
    logic           exact_q, cough_q;
    logic           hs;
    logic [CNT_W-1:0] q_nx, d_nx, n_nx;

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [CNT_W-1:0] b
    );
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // Post-handshake owed/inventory, fed to the selector
    // so the next coin is known in the same cycle
    always_comb begin
        hs      = (state_q == DISPENSE) && bus.coin_ready;
        take    = hs ? (AMT_W+1)'(coin_val(coin_q)) : '0;
        owed_nx = owed_q - take;
        q_nx    = inv_q - CNT_W'(hs && coin_q == QUARTER);
        d_nx    = inv_d - CNT_W'(hs && coin_q == DIME);
        n_nx    = inv_n - CNT_W'(hs && coin_q == NICKEL);
    end

    coin_select #(
        .AMT_W(AMT_W),
        .CNT_W(CNT_W)
    ) u_sel (
        .owed (owed_nx[AMT_W-1:0]),
        .q    (q_nx),
        .d    (d_nx),
        .n    (n_nx),
        .coin (sel)
    );

    // Next state and handshake/status outputs
    always_comb begin
        state_d               = state_q;
        bus.txn_ready         = 1'b0;
        bus.coin_valid        = 1'b0;
        bus.coin_value        = NONE;
        bus.done              = 1'b0;
        bus.exact_amount      = 1'b0;
        bus.cough_up_more     = 1'b0;
        bus.not_enough_change = 1'b0;
        bus.remaining         = '0;
        unique case (state_q)
            IDLE: begin
                bus.txn_ready = !restock_valid;
                if (bus.txn_valid && !restock_valid)
                    state_d = CHECK;
            end
            CHECK: begin
                if (owed_q == '0 || owed_q[AMT_W])
                    state_d = DONE;
                else if (sel == NONE)
                    state_d = DONE;
                else
                    state_d = DISPENSE;
            end
            DISPENSE: begin
                bus.coin_valid = 1'b1;
                bus.coin_value = coin_q;
                if (hs && sel == NONE)
                    state_d = DONE;
            end
            DONE: begin
                bus.done              = 1'b1;
                bus.exact_amount      = exact_q;
                bus.cough_up_more     = cough_q;
                bus.not_enough_change = (owed_q != '0) && !cough_q;
                bus.remaining         = cough_q ? '0 : owed_q[AMT_W-1:0];
                state_d               = IDLE;
            end
        endcase
    end

    // State, owed, current coin and inventory registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owed_q  <= '0;
            coin_q  <= NONE;
            exact_q <= 1'b0;
            cough_q <= 1'b0;
            inv_q   <= '0;
            inv_d   <= '0;
            inv_n   <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (restock_valid) begin
                        inv_q <= sat_add(inv_q, restock_q);
                        inv_d <= sat_add(inv_d, restock_d);
                        inv_n <= sat_add(inv_n, restock_n);
                    end else if (bus.txn_valid) begin
                        owed_q  <= {1'b0, bus.paid} - {1'b0, bus.cost};
                        exact_q <= 1'b0;
                        cough_q <= 1'b0;
                    end
                end
                CHECK: begin
                    exact_q <= (owed_q == '0);
                    cough_q <= owed_q[AMT_W];
                    coin_q  <= sel;
                end
                DISPENSE: begin
                    if (hs) begin
                        owed_q <= owed_nx;
                        inv_q  <= q_nx;
                        inv_d  <= d_nx;
                        inv_n  <= n_nx;
                        coin_q <= sel;
                    end
                end
                DONE: begin
                    coin_q <= NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser_seq.sv
// Randomised self-checking bench for change_dispenser_seq
// against a greedy arithmetic model of the dispenser.
module tb_change_dispenser_seq;

    typedef struct {
        int exact;
        int cough;
        int nec;
        int rem;
        int q;
        int d;
        int n;
    } st_t;

    logic       clk = 0;
    logic       reset = 1;
    logic       restock_valid = 0;
    logic [3:0] restock_q = 0;
    logic [3:0] restock_d = 0;
    logic [3:0] restock_n = 0;
    logic [3:0] inv_q, inv_d, inv_n;

    change_dispenser_seq_if #(.AMT_W(6)) bus ();

    change_dispenser_seq #(
        .AMT_W(6),
        .CNT_W(4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .restock_valid (restock_valid),
        .restock_q     (restock_q),
        .restock_d     (restock_d),
        .restock_n     (restock_n),
        .bus           (bus.slave),
        .inv_q         (inv_q),
        .inv_d         (inv_d),
        .inv_n         (inv_n)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int mq = 0, md = 0, mn = 0;
    int eq[$];
    st_t sq[$];
    int done_cnt = 0;
    int cap_exact, cap_cough, cap_nec, cap_rem;
    int lat_coin, lat_done;
    int pv = 0, pr = 0, pval = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Greedy reference: full transaction outcome at handshake time
    task automatic model(input int c, input int p);
        st_t s;
        int o;
        o = p - c;
        s.exact = (o == 0) ? 1 : 0;
        s.cough = (o < 0) ? 1 : 0;
        while (o > 0) begin
            if (o >= 5 && mq > 0) begin
                mq--; o -= 5; eq.push_back(5);
            end else if (o >= 2 && md > 0) begin
                md--; o -= 2; eq.push_back(2);
            end else if (o >= 1 && mn > 0) begin
                mn--; o -= 1; eq.push_back(1);
            end else begin
                break;
            end
        end
        s.rem = (o > 0) ? o : 0;
        s.nec = (o > 0) ? 1 : 0;
        s.q = mq;
        s.d = md;
        s.n = mn;
        sq.push_back(s);
    endtask

    // Compare process: coins, hold stability and done status
    always @(negedge clk) begin
        if (reset) begin
            pv = 0; pr = 0; pval = 0;
        end else begin
            if (!bus.coin_valid) begin
                chk("idle_value", int'(bus.coin_value), 0);
            end else begin
                if (pv == 1 && pr == 0)
                    chk("hold", int'(bus.coin_value), pval);
                if (bus.coin_ready) begin
                    if (eq.size() == 0) chk("extra_coin", 1, 0);
                    else chk("coin", int'(bus.coin_value), eq.pop_front());
                end
            end
            pv = int'(bus.coin_valid);
            pr = int'(bus.coin_ready);
            pval = int'(bus.coin_value);
            if (bus.done) begin
                st_t s;
                done_cnt++;
                cap_exact = int'(bus.exact_amount);
                cap_cough = int'(bus.cough_up_more);
                cap_nec = int'(bus.not_enough_change);
                cap_rem = int'(bus.remaining);
                if (sq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    s = sq.pop_front();
                    chk("exact", cap_exact, s.exact);
                    chk("cough", cap_cough, s.cough);
                    chk("nec", cap_nec, s.nec);
                    chk("remaining", cap_rem, s.rem);
                    chk("inv_q", int'(inv_q), s.q);
                    chk("inv_d", int'(inv_d), s.d);
                    chk("inv_n", int'(inv_n), s.n);
                    chk("coins_left", eq.size(), 0);
                end
            end
        end
    end

    // Entry/exit: just after a rising edge
    task automatic restock(input int q, input int d, input int n);
        restock_valid = 1;
        restock_q = 4'(q);
        restock_d = 4'(d);
        restock_n = 4'(n);
        @(posedge clk);
        mq = (mq + q > 15) ? 15 : mq + q;
        md = (md + d > 15) ? 15 : md + d;
        mn = (mn + n > 15) ? 15 : mn + n;
        #1 restock_valid = 0;
        @(negedge clk);
        chk("rs_q", int'(inv_q), mq);
        chk("rs_d", int'(inv_d), md);
        chk("rs_n", int'(inv_n), mn);
        @(posedge clk);
        #1;
    endtask

    // Runs after the handshake edge until done (bounded)
    task automatic run_dispense(input int mode);
        bit got;
        got = 0;
        lat_coin = 0;
        lat_done = 0;
        for (int i = 1; i <= 200; i++) begin
            if (mode == 1) bus.coin_ready = 1;
            else if (mode == 2) bus.coin_ready = (i >= 5);
            else bus.coin_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.coin_valid && lat_coin == 0) lat_coin = i;
            if (bus.done) begin
                got = 1;
                lat_done = i;
            end
            @(posedge clk);
            #1;
            if (got) break;
        end
        bus.coin_ready = 0;
        if (!got) chk("timeout_done", 0, 1);
    endtask

    task automatic do_txn(input int c, input int p, input int mode);
        int n;
        n = 0;
        while (!bus.txn_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.txn_ready) chk("timeout_ready", 0, 1);
        bus.txn_valid = 1;
        bus.cost = 6'(c);
        bus.paid = 6'(p);
        @(posedge clk);
        model(c, p);
        #1 bus.txn_valid = 0;
        run_dispense(mode);
    endtask

    initial begin
        int snap, c, p;
        bus.txn_valid = 0;
        bus.cost = 0;
        bus.paid = 0;
        bus.coin_ready = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_ready", int'(bus.txn_ready), 1);
        chk("rst_cvalid", int'(bus.coin_valid), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_flags", int'({bus.exact_amount, bus.cough_up_more,
                                bus.not_enough_change}), 0);
        chk("rst_rem", int'(bus.remaining), 0);
        chk("rst_inv", int'({inv_q, inv_d, inv_n}), 0);
        @(posedge clk);
        #1;

        // Exact payment
        restock(2, 2, 2);
        do_txn(10, 10, 1);
        chk("ex_lat", lat_done, 2);
        chk("ex_nocoin", lat_coin, 0);
        chk("ex_flag", cap_exact, 1);
        chk("ex_rem", cap_rem, 0);

        // Underpaid
        do_txn(12, 7, 1);
        chk("up_cough", cap_cough, 1);
        chk("up_nec", cap_nec, 0);
        chk("up_lat", lat_done, 2);

        // Greedy Q,Q,D
        restock(1, 1, 1);
        do_txn(2, 14, 1);
        chk("gr_first", lat_coin, 2);
        chk("gr_lat", lat_done, 5);
        chk("gr_rem", cap_rem, 0);
        chk("gr_inv", int'({inv_q, inv_d, inv_n}), 12'h123);

        // Reset after the first coin of owed 10
        bus.txn_valid = 1;
        bus.cost = 0;
        bus.paid = 10;
        @(posedge clk);
        model(0, 10);
        #1 bus.txn_valid = 0;
        bus.coin_ready = 1;
        @(posedge clk);
        @(posedge clk);
        snap = done_cnt;
        #1 reset = 1;
        @(posedge clk);
        @(negedge clk);
        chk("mr_cvalid", int'(bus.coin_valid), 0);
        chk("mr_value", int'(bus.coin_value), 0);
        chk("mr_ready", int'(bus.txn_ready), 1);
        chk("mr_inv", int'({inv_q, inv_d, inv_n}), 0);
        #1 reset = 0;
        bus.coin_ready = 0;
        eq.delete();
        sq.delete();
        mq = 0; md = 0; mn = 0;
        @(posedge clk);
        #1;
        chk("mr_nodone", done_cnt, snap);

        // Shortfall with backpressure
        restock(1, 3, 0);
        do_txn(0, 6, 2);
        chk("sf_first", lat_coin, 2);
        chk("sf_lat", lat_done, 6);
        chk("sf_nec", cap_nec, 1);
        chk("sf_rem", cap_rem, 1);

        // Restock wins over txn, with saturation
        restock(14, 0, 0);
        restock_valid = 1;
        restock_q = 5;
        restock_d = 0;
        restock_n = 0;
        bus.txn_valid = 1;
        bus.cost = 5;
        bus.paid = 5;
        @(negedge clk);
        chk("pr_ready0", int'(bus.txn_ready), 0);
        @(posedge clk);
        mq = 15;
        #1 restock_valid = 0;
        @(negedge clk);
        chk("pr_sat", int'(inv_q), 15);
        chk("pr_ready1", int'(bus.txn_ready), 1);
        @(posedge clk);
        model(5, 5);
        #1 bus.txn_valid = 0;
        run_dispense(1);
        chk("pr_exact", cap_exact, 1);

        // Random traffic
        for (int k = 0; k < 250; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                restock($urandom_range(0, 15), $urandom_range(0, 15),
                        $urandom_range(0, 15));
            end else begin
                c = $urandom_range(0, 63);
                if ($urandom_range(0, 3) == 0) p = $urandom_range(0, 63);
                else p = c + $urandom_range(0, 63 - c);
                do_txn(c, p, $urandom_range(0, 2));
            end
        end

        chk("final_queue", sq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/change_dispenser_seq.md
Name: change_dispenser_seq

Overview:
- Sequential, parametrised change dispenser that holds its own coin inventory.
- Accepts one transaction (cost, paid) at a time and computes the change owed.
- Dispenses the change one coin per handshake, largest coin first, and decrements inventory as each coin leaves.
- Sits between the payment front-end and the coin ejector; reports the final status once per transaction.

Parameters:
- AMT_W, 6, width of cost/paid/remaining, in nickel units (max 63 nickels = $3.15).
- CNT_W, 4, width of each coin inventory counter (max 15 coins per type).

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- restock_valid  in  1  add coins to inventory.
- restock_q  in  CNT_W  quarters to add.
- restock_d  in  CNT_W  dimes to add.
- restock_n  in  CNT_W  nickels to add.
- txn_valid  in  1  transaction offered.
- txn_ready  out  1  block can accept a transaction.
- cost  in  AMT_W  item price, in nickels, unsigned.
- paid  in  AMT_W  amount paid, in nickels, unsigned.
- coin_valid  out  1  coin_value is presented.
- coin_ready  in  1  ejector takes the coin.
- coin_value  out  3  3'b101 quarter, 3'b010 dime, 3'b001 nickel, 3'b000 when idle.
- done  out  1  one-cycle status pulse at the end of each transaction.
- exact_amount  out  1  paid == cost; valid with done.
- cough_up_more  out  1  paid < cost; valid with done.
- not_enough_change  out  1  change was owed and could not be completed; valid with done.
- remaining  out  AMT_W  nickels still owed; valid with done.
- inv_q, inv_d, inv_n  out  CNT_W each  current inventory.

Behaviour:
- Reset values: state IDLE; all inventory 0; txn_ready 1; coin_valid 0; coin_value 0; done 0; all flags 0; remaining 0.
- Reset asserted mid-dispense aborts the transaction immediately: no done pulse, already-dispensed coins stay deducted.
- States:
  - IDLE: txn_ready = 1 unless restock_valid is high (restock wins, txn_ready = 0). On txn_valid & txn_ready, latch owed = paid - cost (AMT_W+1 wide compare) and go to CHECK.
  - CHECK (1 cycle): if paid == cost, set exact_amount and go to DONE. If paid < cost, set cough_up_more, remaining = 0, and go to DONE. Otherwise select a coin per the rule below and go to DISPENSE; if no coin is eligible, go to DONE.
  - DISPENSE: coin_valid = 1 and coin_value is stable until coin_ready. On handshake:
    - owed -= coin value (5/2/1) and the matching inventory decrements.
    - Reselect; if owed == 0 or no coin is eligible, go to DONE, else present the next coin on the following cycle.
  - DONE (1 cycle): done = 1, remaining = owed, not_enough_change = (owed != 0) & !cough_up_more; return to IDLE. Flags clear the cycle after done.
- Coin selection is pure greedy:
  - Take the quarter if owed >= 5 and inv_q > 0.
  - Else the dime if owed >= 2 and inv_d > 0.
  - Else the nickel if owed >= 1 and inv_n > 0.
  - No backtracking. Example: owed 6 with inv_q 1, inv_d 3, inv_n 0 dispenses a quarter, then flags not_enough_change with remaining 1.
- Latency: txn handshake at cycle 0 -> first coin_valid at cycle 2. With coin_ready held high, one coin is dispensed per cycle. Exact or underpaid transactions pulse done at cycle 2.
- Restock:
  - Accepted only in IDLE; ignored in every other state.
  - Each counter adds with saturation at 2^CNT_W-1.
  - Restock takes priority over a same-cycle txn_valid.
- coin_ready while coin_valid = 0 is ignored. Transaction inputs are sampled only at the handshake.

Decomposition:
- Package change_pkg holds:
  - coin_e enum (NONE = 3'b000, NICKEL = 3'b001, DIME = 3'b010, QUARTER = 3'b101).
  - Nickel-value constants Q_VAL = 5, D_VAL = 2, N_VAL = 1.
  - state_e enum (IDLE, CHECK, DISPENSE, DONE).
- One combinational sub-module, coin_select, takes owed and the three inventory counts and returns coin_e. It is instantiated once, in the top.

Test Plan:
- Exact payment: cost 10, paid 10, inventory 2/2/2 -> no coin_valid; done at cycle 2 with exact_amount = 1, remaining = 0; inventory unchanged.
- Underpaid: cost 12, paid 7 -> done with cough_up_more = 1, not_enough_change = 0, no coins dispensed.
- Greedy full change: inventory q3 d3 n3, cost 2, paid 14 (owed 12) -> coins Q, Q, D, each one cycle apart with coin_ready high; done with remaining 0; inventory q1 d2 n3.
- Shortfall and backpressure: inventory q1 d3 n0, owed 6, coin_ready low for 3 cycles -> Q held stable until accepted; done with not_enough_change = 1, remaining = 1.
- Restock priority and saturation: inv_q = 14; restock_q = 5 with txn_valid in the same cycle -> inv_q = 15, txn_ready = 0 that cycle; transaction accepted the next cycle.
- Reset mid-dispense: reset after the first coin handshake of owed 10 -> all outputs return to reset values next cycle with no done pulse; inventory is cleared to 0.
